// File: rtl/nios_system_nrf_pkg.sv
// Shared constants for the nRF IRQ master: FSM state encoding, slave register map, mask values.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package nios_system_nrf_pkg;

    // FSM state encoding (3 bits, legacy-compatible constants)
    localparam logic [2:0] ST_INIT_WR   = 3'd0;
    localparam logic [2:0] ST_ARMED     = 3'd1;
    localparam logic [2:0] ST_MASK_WR   = 3'd2;
    localparam logic [2:0] ST_RD_ADDR   = 3'd3;
    localparam logic [2:0] ST_RD_WAIT   = 3'd4;
    localparam logic [2:0] ST_OUT_HOLD  = 3'd5;
    localparam logic [2:0] ST_UNMASK_WR = 3'd6;

    // PIO slave register map
    localparam int ADDR_DATA_DEF = 0;
    localparam int ADDR_MASK_DEF = 2;

    // irq_mask values
    localparam int MASK_ARM    = 1;
    localparam int MASK_DISARM = 0;

endpackage

// File: rtl/nios_system_nrf_irq_master.sv
// Services the nRF IRQ PIO in hardware: mask irq, read data register, stream sample, re-arm mask.
// Latency: irq in ARMED -> sample_valid after 3+READ_LATENCY clocks; bus outputs are registered.
// Backpressure: sample held stable until sample_ready; the mask stays disarmed meanwhile, no bus traffic.
module nios_system_nrf_irq_master
    import nios_system_nrf_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_DATA    = ADDR_DATA_DEF,
    parameter int ADDR_MASK    = ADDR_MASK_DEF,
    parameter int MASK_VALUE   = MASK_ARM,
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              irq,
    output logic [1:0]        address,
    output logic              chipselect,
    output logic              write_n,
    output logic [DATA_W-1:0] writedata,
    input  logic [DATA_W-1:0] readdata,
    output logic [DATA_W-1:0] sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  event_count
);

    logic [2:0]        state_q,        state_d;
    logic [1:0]        lat_cnt_q,      lat_cnt_d;
    logic [1:0]        address_q,      address_d;
    logic              chipselect_q,   chipselect_d;
    logic              write_n_q,      write_n_d;
    logic [DATA_W-1:0] writedata_q,    writedata_d;
    logic [DATA_W-1:0] sample_data_q,  sample_data_d;
    logic              sample_valid_q, sample_valid_d;
    logic [CNT_W-1:0]  event_count_q,  event_count_d;

    // Next-state and registered bus outputs. A bus cycle is computed on the transition into the
    // state that owns it, so the write/read appears on the bus during MASK_WR, RD_ADDR and
    // UNMASK_WR. INIT_WR is only entered by reset, so its write lands in the first ARMED cycle.
    always_comb begin
        state_d        = state_q;
        lat_cnt_d      = lat_cnt_q;
        address_d      = address_q;
        chipselect_d   = 1'b0;
        write_n_d      = 1'b1;
        writedata_d    = writedata_q;
        sample_data_d  = sample_data_q;
        sample_valid_d = sample_valid_q;
        event_count_d  = event_count_q;

        case (state_q)
            ST_INIT_WR: begin
                address_d    = 2'(ADDR_MASK);
                chipselect_d = 1'b1;
                write_n_d    = 1'b0;
                writedata_d  = DATA_W'(MASK_VALUE);
                state_d      = ST_ARMED;
            end
            ST_ARMED: begin
                if (enable && irq) begin
                    address_d    = 2'(ADDR_MASK);
                    chipselect_d = 1'b1;
                    write_n_d    = 1'b0;
                    writedata_d  = DATA_W'(MASK_DISARM);
                    state_d      = ST_MASK_WR;
                end
            end
            ST_MASK_WR: begin
                // read address cycle for the data register
                address_d    = 2'(ADDR_DATA);
                chipselect_d = 1'b1;
                state_d      = ST_RD_ADDR;
            end
            ST_RD_ADDR: begin
                lat_cnt_d = 2'(READ_LATENCY);
                state_d   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                lat_cnt_d = lat_cnt_q - 2'd1;
                if (lat_cnt_q == 2'd1) begin
                    sample_data_d  = readdata;
                    sample_valid_d = 1'b1;
                    state_d        = ST_OUT_HOLD;
                end
            end
            ST_OUT_HOLD: begin
                if (sample_valid_q && sample_ready) begin
                    sample_valid_d = 1'b0;
                    event_count_d  = event_count_q + CNT_W'(1);
                    address_d      = 2'(ADDR_MASK);
                    chipselect_d   = 1'b1;
                    write_n_d      = 1'b0;
                    writedata_d    = DATA_W'(MASK_VALUE);
                    state_d        = ST_UNMASK_WR;
                end
            end
            ST_UNMASK_WR: begin
                state_d = ST_ARMED;
            end
            default: begin
                state_d = ST_INIT_WR;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight service and drops a pending sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_INIT_WR;
            lat_cnt_q      <= 2'd0;
            address_q      <= 2'd0;
            chipselect_q   <= 1'b0;
            write_n_q      <= 1'b1;
            writedata_q    <= '0;
            sample_data_q  <= '0;
            sample_valid_q <= 1'b0;
            event_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            lat_cnt_q      <= lat_cnt_d;
            address_q      <= address_d;
            chipselect_q   <= chipselect_d;
            write_n_q      <= write_n_d;
            writedata_q    <= writedata_d;
            sample_data_q  <= sample_data_d;
            sample_valid_q <= sample_valid_d;
            event_count_q  <= event_count_d;
        end
    end

    assign address      = address_q;
    assign chipselect   = chipselect_q;
    assign write_n      = write_n_q;
    assign writedata    = writedata_q;
    assign sample_data  = sample_data_q;
    assign sample_valid = sample_valid_q;
    assign event_count  = event_count_q;
    assign busy         = (state_q != ST_ARMED);

endmodule

// File: tb/tb_nios_system_nrf_irq_master.sv
// Directed bench: two masters (READ_LATENCY=1/CNT_W=16 and READ_LATENCY=3/CNT_W=4), each paired
// with a behavioural PIO slave (in_port, irq_mask at addr 2, registered readdata, level irq).
module tb_nios_system_nrf_irq_master;

    logic clk;
    logic reset;

    // DUT A: default parameters
    logic        en_a, rdy_a, irq_a, cs_a, wn_a, vld_a, busy_a;
    logic [1:0]  addr_a;
    logic [31:0] wd_a, rd_a, dat_a;
    logic [15:0] cnt_a;
    logic [7:0]  in_a, mask_a;
    logic [31:0] rd_a1;

    // DUT B: READ_LATENCY=3, CNT_W=4
    logic        en_b, rdy_b, irq_b, cs_b, wn_b, vld_b, busy_b;
    logic [1:0]  addr_b;
    logic [31:0] wd_b, rd_b, dat_b;
    logic [3:0]  cnt_b;
    logic [7:0]  in_b, mask_b;
    logic [31:0] rd_b1, rd_b2, rd_b3;

    int bus_cnt_a;
    int total  = 0;
    int passed = 0;

    nios_system_nrf_irq_master u_dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .irq(irq_a),
        .address(addr_a), .chipselect(cs_a), .write_n(wn_a), .writedata(wd_a),
        .readdata(rd_a), .sample_data(dat_a), .sample_valid(vld_a), .sample_ready(rdy_a),
        .busy(busy_a), .event_count(cnt_a)
    );

    nios_system_nrf_irq_master #(.READ_LATENCY(3), .CNT_W(4)) u_dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .irq(irq_b),
        .address(addr_b), .chipselect(cs_b), .write_n(wn_b), .writedata(wd_b),
        .readdata(rd_b), .sample_data(dat_b), .sample_valid(vld_b), .sample_ready(rdy_b),
        .busy(busy_b), .event_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pio_mux(input logic [1:0] a, input logic [7:0] din,
                                            input logic [7:0] m);
        if (a == 2'd0)      return {24'd0, din};
        else if (a == 2'd2) return {24'd0, m};
        else                return 32'd0;
    endfunction

    // PIO slave models and bus-cycle monitor
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_a    <= 8'd0;
            mask_b    <= 8'd0;
            bus_cnt_a <= 0;
        end else begin
            if (cs_a && !wn_a && addr_a == 2'd2) mask_a <= wd_a[7:0];
            if (cs_b && !wn_b && addr_b == 2'd2) mask_b <= wd_b[7:0];
            if (cs_a) bus_cnt_a <= bus_cnt_a + 1;
        end
        rd_a1 <= pio_mux(addr_a, in_a, mask_a);
        rd_b1 <= pio_mux(addr_b, in_b, mask_b);
        rd_b2 <= rd_b1;
        rd_b3 <= rd_b2;
    end

    assign rd_a  = rd_a1;
    assign rd_b  = rd_b3;
    assign irq_a = |(in_a & mask_a);
    assign irq_b = |(in_b & mask_b);

    initial begin
        #2000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    int snap;
    int guard;

    initial begin
        reset = 1'b1;
        en_a = 0; rdy_a = 0; in_a = 8'd0;
        en_b = 0; rdy_b = 0; in_b = 8'd0;
        tick(3);

        // Reset values
        chk("rst_addr",  {30'd0, addr_a}, 32'd0);
        chk("rst_cs",    {31'd0, cs_a}, 32'd0);
        chk("rst_wn",    {31'd0, wn_a}, 32'd1);
        chk("rst_wd",    wd_a, 32'd0);
        chk("rst_data",  dat_a, 32'd0);
        chk("rst_vld",   {31'd0, vld_a}, 32'd0);
        chk("rst_cnt",   {16'd0, cnt_a}, 32'd0);
        chk("rst_busy",  {31'd0, busy_a}, 32'd1);

        // Release: cycle 0 is INIT_WR, cycle 1 carries the mask write
        reset = 1'b0;
        chk("init_c0_cs", {31'd0, cs_a}, 32'd0);
        tick();
        chk("init_wr", {cs_a, wn_a, addr_a, wd_a[27:0]}, {1'b1, 1'b0, 2'd2, 28'd1});
        chk("init_busy", {31'd0, busy_a}, 32'd0);
        tick();
        chk("init_cs_idle", {31'd0, cs_a}, 32'd0);
        chk("slave_mask", {24'd0, mask_a}, 32'd1);

        // Basic service: in_port=1, enable=1 (cycle n)
        in_a = 8'd1; en_a = 1'b1;
        tick();   // n+1 MASK_WR
        chk("svc_mask_wr", {cs_a, wn_a, addr_a, wd_a[27:0]}, {1'b1, 1'b0, 2'd2, 28'd0});
        chk("svc_busy", {31'd0, busy_a}, 32'd1);
        tick();   // n+2 RD_ADDR
        chk("svc_rd", {29'd0, cs_a, wn_a, addr_a[0]}, {29'd0, 1'b1, 1'b1, 1'b0});
        chk("svc_rd_addr", {30'd0, addr_a}, 32'd0);
        chk("svc_irq_drop", {31'd0, irq_a}, 32'd0);
        tick();   // n+3 RD_WAIT
        chk("svc_vld_n3", {31'd0, vld_a}, 32'd0);
        chk("svc_cs_n3", {31'd0, cs_a}, 32'd0);
        tick();   // n+4 OUT_HOLD
        chk("svc_vld_n4", {31'd0, vld_a}, 32'd1);
        chk("svc_data", dat_a, 32'd1);
        in_a = 8'd0;

        // Hold off the consumer for 10 cycles
        snap = bus_cnt_a;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_vld_data", {vld_a, dat_a[30:0]}, {1'b1, 31'd1});
        end
        chk("hold_no_bus", bus_cnt_a, snap);
        chk("hold_cnt", {16'd0, cnt_a}, 32'd0);
        rdy_a = 1'b1;
        tick();   // UNMASK_WR
        chk("unmask_wr", {cs_a, wn_a, addr_a, wd_a[27:0]}, {1'b1, 1'b0, 2'd2, 28'd1});
        chk("accept_vld", {31'd0, vld_a}, 32'd0);
        chk("accept_cnt", {16'd0, cnt_a}, 32'd1);
        rdy_a = 1'b0;
        tick();
        chk("rearm_busy", {31'd0, busy_a}, 32'd0);
        chk("rearm_cs", {31'd0, cs_a}, 32'd0);

        // enable=0 with irq pending: no bus cycles
        en_a = 1'b0; in_a = 8'hA5;
        snap = bus_cnt_a;
        tick(5);
        chk("dis_no_bus", bus_cnt_a, snap);
        chk("dis_busy", {31'd0, busy_a}, 32'd0);
        chk("dis_irq", {31'd0, irq_a}, 32'd1);
        en_a = 1'b1;   // cycle n
        tick();        // n+1
        chk("en_start", {cs_a, wn_a, addr_a, wd_a[27:0]}, {1'b1, 1'b0, 2'd2, 28'd0});
        tick(3);       // n+4
        chk("en_vld", {31'd0, vld_a}, 32'd1);
        chk("en_data", dat_a, 32'h0000_00A5);
        rdy_a = 1'b1;
        tick();        // n+5 UNMASK_WR
        chk("en_cnt", {16'd0, cnt_a}, 32'd2);
        tick();        // n+6 ARMED, irq still high
        chk("again_busy", {31'd0, busy_a}, 32'd0);
        tick();        // n+7 immediate new service
        chk("again_start", {cs_a, wn_a, addr_a, wd_a[27:0]}, {1'b1, 1'b0, 2'd2, 28'd0});
        en_a = 1'b0;   // dropped mid-service: must still complete
        tick(3);       // n+10
        chk("midoff_vld", {31'd0, vld_a}, 32'd1);
        chk("midoff_data", dat_a, 32'h0000_00A5);
        in_a = 8'd0;
        tick();        // n+11
        chk("midoff_cnt", {16'd0, cnt_a}, 32'd3);
        tick();
        rdy_a = 1'b0;
        chk("midoff_idle", {31'd0, busy_a}, 32'd0);

        // Counter wrap on DUT B (CNT_W=4): continuous services
        en_b = 1'b1; in_b = 8'd1; rdy_b = 1'b1;
        guard = 0;
        while (cnt_b != 4'hF && guard < 400) begin tick(); guard++; end
        chk("wrap_reach_max", {28'd0, cnt_b}, 32'hF);
        guard = 0;
        while (cnt_b == 4'hF && guard < 40) begin tick(); guard++; end
        chk("wrap_zero", {28'd0, cnt_b}, 32'd0);
        chk("wrap_data", dat_b, 32'd1);

        // Reset during RD_WAIT of DUT A (cycle n)
        in_a = 8'd1; en_a = 1'b1;
        tick(3);       // n+3 RD_WAIT
        chk("pre_rst_busy", {31'd0, busy_a}, 32'd1);
        reset = 1'b1; en_a = 1'b0; in_a = 8'd0;
        in_b = 8'h81; rdy_b = 1'b0;
        tick();
        chk("mid_rst_vld", {31'd0, vld_a}, 32'd0);
        chk("mid_rst_cnt", {16'd0, cnt_a}, 32'd0);
        chk("mid_rst_cs", {31'd0, cs_a}, 32'd0);
        chk("mid_rst_cnt_b", {28'd0, cnt_b}, 32'd0);
        tick();
        reset = 1'b0;  // cycle 0: INIT_WR
        chk("post_rst_busy", {31'd0, busy_a}, 32'd1);
        tick();        // cycle 1
        chk("post_rst_wr", {cs_a, wn_a, addr_a, wd_a[27:0]}, {1'b1, 1'b0, 2'd2, 28'd1});
        chk("post_rst_b_irq", {31'd0, irq_b}, 32'd0);
        tick();        // cycle 2: DUT B armed with irq high
        chk("b_armed_irq", {busy_b, irq_b}, {1'b0, 1'b1});
        tick(5);       // cycle 7
        chk("b_vld_p5", {31'd0, vld_b}, 32'd0);
        tick();        // cycle 8 = +6
        chk("b_vld_p6", {31'd0, vld_b}, 32'd1);
        chk("b_data", dat_b, 32'h0000_0081);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
